// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: shifts one {rw, addr, data} frame per request and
// returns the data field sampled from miso as rdata on reads.
module spi_reg_master #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N     = 1 + ADDR_W + REG_W;
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [BIT_W-1:0]   bit_r, bit_s;
  logic [N-1:0]       shreg_r, shreg_s, frame_s;
  logic [REG_W-1:0]   rx_r, rx_s, rdata_r, rdata_s;
  logic               rw_r, rw_s;
  logic               cs_n_r, cs_n_s, sclk_r, sclk_s, mosi_r, mosi_s;
  logic               busy_r, busy_s, done_r, done_s, last_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign rdata    = rdata_r;
  assign spi_cs_n = cs_n_r;
  assign spi_clk  = sclk_r;
  assign spi_mosi = mosi_r;

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      shreg_r <= {N{1'b0}};
      rx_r    <= {REG_W{1'b0}};
      rdata_r <= {REG_W{1'b0}};
      rw_r    <= 1'b0;
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      rx_r    <= rx_s;
      rdata_r <= rdata_s;
      rw_r    <= rw_s;
      cs_n_r  <= cs_n_s;
      sclk_r  <= sclk_s;
      mosi_r  <= mosi_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-output logic; outputs are registered so pins never glitch
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_W'(1);
    bit_s   = bit_r;
    shreg_s = shreg_r;
    rx_s    = rx_r;
    rdata_s = rdata_r;
    rw_s    = rw_r;
    cs_n_s  = 1'b1;
    sclk_s  = 1'b0;
    mosi_s  = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    last_s  = (cnt_r == CNT_LAST);
    frame_s = {rw, addr, rw ? wdata : {REG_W{1'b0}}};
    case (state_r)
      IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (start) begin
          state_s = LEAD;
          bit_s   = {BIT_W{1'b0}};
          rw_s    = rw;
          shreg_s = frame_s;
          cs_n_s  = 1'b0;
          mosi_s  = frame_s[N-1];
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LEAD: begin
        cs_n_s = 1'b0;
        busy_s = 1'b1;
        mosi_s = shreg_r[N-1];
        if (last_s) begin
          state_s = XFER;
          cnt_s   = {CNT_W{1'b0}};
          sclk_s  = 1'b1;
          rx_s    = {rx_r[REG_W-2:0], spi_miso};
        end else begin
          sclk_s = 1'b0;
        end
      end
      XFER: begin
        cs_n_s = 1'b0;
        busy_s = 1'b1;
        // sclk_r tells which half of the bit period we are in
        if (sclk_r) begin
          if (last_s) begin
            cnt_s   = {CNT_W{1'b0}};
            sclk_s  = 1'b0;
            shreg_s = {shreg_r[N-2:0], 1'b0};
            mosi_s  = shreg_r[N-2];
            bit_s   = bit_r + BIT_W'(1);
            state_s = (bit_r == BIT_LAST) ? TRAIL : XFER;
          end else begin
            sclk_s = 1'b1;
            mosi_s = shreg_r[N-1];
          end
        end else begin
          mosi_s = shreg_r[N-1];
          if (last_s) begin
            cnt_s  = {CNT_W{1'b0}};
            sclk_s = 1'b1;
            rx_s   = {rx_r[REG_W-2:0], spi_miso};
          end else begin
            sclk_s = 1'b0;
          end
        end
      end
      TRAIL: begin
        busy_s = 1'b1;
        if (last_s) begin
          state_s = GAP;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cs_n_s = 1'b0;
          mosi_s = shreg_r[N-1];
        end
      end
      GAP: begin
        if (last_s) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
          done_s  = 1'b1;
          if (!rw_r) begin
            rdata_s = rx_r;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: doc/spi_reg_master.md
SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: register address width.
REQ-002 SHALL have parameter REG_W, default 8: register data width.
REQ-003 SHALL have parameter CLK_DIV, default 4: spi_clk half-period in clk cycles; legal range CLK_DIV >= 2.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: transaction request, sampled each clk.
REQ-007 SHALL have port rw  input  1: 1 = register write, 0 = register read; captured with start.
REQ-008 SHALL have port addr  input  ADDR_W: target register address; captured with start.
REQ-009 SHALL have port wdata  input  REG_W: write data; captured with start.
REQ-010 SHALL have port busy  output  1: transaction in progress.
REQ-011 SHALL have port done  output  1: single-cycle completion pulse.
REQ-012 SHALL have port rdata  output  REG_W: data returned by the last read.
REQ-013 SHALL have port spi_cs_n  output  1: active-low chip select.
REQ-014 SHALL have port spi_clk  output  1: serial clock, idle low.
REQ-015 SHALL have port spi_mosi  output  1: serial data out.
REQ-016 SHALL have port spi_miso  input  1: serial data in, treated as synchronous to clk.

Function
REQ-017 SHALL send frames of N = 1+ADDR_W+REG_W bits, MSB first: rw, addr[ADDR_W-1:0], data[REG_W-1:0] (N = 12 at defaults).
REQ-018 SHALL drive wdata in the data field for writes and all-zero for reads.
REQ-019 SHALL use SPI mode 0: spi_mosi changes only while spi_clk is low; spi_miso sampled in the clk cycle in which spi_clk rises.
REQ-020 SHALL implement FSM IDLE -> LEAD -> XFER -> TRAIL -> GAP -> IDLE.
REQ-021 SHALL accept start only in IDLE; start while busy is ignored, with no queuing.
REQ-022 SHALL, for start accepted at edge T, drive spi_cs_n low and spi_mosi = bit N-1 from cycle T+1 (LEAD, spi_clk low, CLK_DIV cycles).
REQ-023 SHALL make each XFER bit spi_clk high for CLK_DIV cycles, then low for CLK_DIV cycles, with the next bit presented on the falling edge; after the final bit, spi_clk ends low.
REQ-024 SHALL hold spi_cs_n low for exactly (2N+1)*CLK_DIV cycles in total (LEAD + XFER + TRAIL of CLK_DIV cycles with spi_clk low).
REQ-025 SHALL hold spi_cs_n high, spi_clk low and busy high for the CLK_DIV cycles of GAP.
REQ-026 SHALL pulse done for exactly one cycle at T+1+(2N+2)*CLK_DIV and drop busy in that same cycle; busy is high from T+1 through T+(2N+2)*CLK_DIV.
REQ-027 SHALL, on reads, shift the last REG_W sampled miso bits (data field) into rdata and update rdata in the done cycle.
REQ-028 SHALL leave rdata unchanged on writes.
REQ-029 SHALL use a counter width sufficient for CLK_DIV and N; no wrap-around glitch may occur at bit or phase boundaries.
REQ-030 SHALL accept start asserted in the same cycle done is high, since the FSM is back in IDLE.
REQ-031 SHALL drive spi_mosi low whenever spi_cs_n is high.

Reset
REQ-032 SHALL, with rst high, force the next clk edge to: FSM IDLE, busy=0, done=0, rdata=0, spi_cs_n=1, spi_clk=0, spi_mosi=0.
REQ-033 SHALL, on reset asserted mid-transaction, abort immediately with no done pulse; spi_cs_n rises on the next edge.
REQ-034 SHALL ignore start while rst is high.

Verification
REQ-035 SHALL cover: reset then idle for 20 cycles -> cs_n=1, spi_clk=0, busy=0, done=0, rdata=0.
REQ-036 SHALL cover: write rw=1, addr=3, wdata=0xA5, defaults -> MOSI frame 1_011_10100101; cs_n low 100 cycles; 12 rising edges; done at T+105; rdata unchanged.
REQ-037 SHALL cover: read addr=6 against a slave model returning 0x3C -> MOSI 0_110_00000000; rdata=0x3C in the done cycle.
REQ-038 SHALL cover: start pulsed mid-transaction -> ignored; frame and done timing identical to REQ-036.
REQ-039 SHALL cover: rst asserted at the 5th rising edge of spi_clk -> next cycle cs_n=1, spi_clk=0, busy=0; no done pulse.
REQ-040 SHALL cover: CLK_DIV=2, back-to-back start on the done cycle -> second frame starts at the next cycle; each spi_clk phase is 2 cycles.
